mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the arbiter and the byte-serial RAM controller.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_flush_in;
    logic        if_valid_out;
    logic [31:0] if_inst_out;

    logic        mem_req_in;
    logic        mem_rw_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_data_in;
    logic [2:0]  mem_len_in;
    logic        mem_done_out;
    logic [31:0] mem_data_out;

    logic        ctrl_if_out;
    logic        ctrl_mem_out;
    logic [31:0] ctrl_addr_out;
    logic        ctrl_rw_out;
    logic [2:0]  ctrl_len_out;
    logic [31:0] ctrl_data_out;
    logic        ctrl_if_done_in;
    logic [31:0] ctrl_if_inst_in;
    logic        ctrl_mem_done_in;
    logic [31:0] ctrl_mem_data_in;

    logic        err_out;

    modport slave (
        input  if_req_in, if_addr_in, if_flush_in,
        input  mem_req_in, mem_rw_in, mem_addr_in, mem_data_in, mem_len_in,
        input  ctrl_if_done_in, ctrl_if_inst_in, ctrl_mem_done_in, ctrl_mem_data_in,
        output if_valid_out, if_inst_out, mem_done_out, mem_data_out,
        output ctrl_if_out, ctrl_mem_out, ctrl_addr_out, ctrl_rw_out, ctrl_len_out, ctrl_data_out,
        output err_out
    );

    modport master (
        output if_req_in, if_addr_in, if_flush_in,
        output mem_req_in, mem_rw_in, mem_addr_in, mem_data_in, mem_len_in,
        output ctrl_if_done_in, ctrl_if_inst_in, ctrl_mem_done_in, ctrl_mem_data_in,
        input  if_valid_out, if_inst_out, mem_done_out, mem_data_out,
        input  ctrl_if_out, ctrl_mem_out, ctrl_addr_out, ctrl_rw_out, ctrl_len_out, ctrl_data_out,
        input  err_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one byte-serial RAM controller,
// with anti-starvation for fetch, fetch flush, and a per-transaction watchdog.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int WDOG_CYCLES  = 64
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DRAIN} state_e;

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   if_inst_q, if_inst_d;
    logic          mem_done_q, mem_done_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          ctrl_if_q, ctrl_if_d;
    logic          ctrl_mem_q, ctrl_mem_d;
    logic [31:0]   ctrl_addr_q, ctrl_addr_d;
    logic          ctrl_rw_q, ctrl_rw_d;
    logic [2:0]    ctrl_len_q, ctrl_len_d;
    logic [31:0]   ctrl_data_q, ctrl_data_d;
    logic          err_q, err_d;

    logic grant_if, grant_mem, wdog_hit, if_fin, mem_fin, wdog_abort;

    // A flushed fetch is invisible to arbitration; MEM wins ties unless fetch has starved.
    assign grant_if   = bus.if_req_in & ~bus.if_flush_in &
                        (~bus.mem_req_in | (starve_q == STARVE_MAX));
    assign grant_mem  = bus.mem_req_in & ~grant_if;
    assign wdog_hit   = (wdog_q == WDOG_LAST);
    assign if_fin     = (state_q == IF_BUSY) & bus.ctrl_if_done_in & ~bus.if_flush_in;
    assign mem_fin    = (state_q == MEM_BUSY) & bus.ctrl_mem_done_in;
    assign wdog_abort = wdog_hit &
                        (((state_q == IF_BUSY) & ~bus.if_flush_in & ~bus.ctrl_if_done_in) |
                         ((state_q == MEM_BUSY) & ~bus.ctrl_mem_done_in));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wdog_q      <= '0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_data_q  <= '0;
            ctrl_if_q   <= 1'b0;
            ctrl_mem_q  <= 1'b0;
            ctrl_addr_q <= '0;
            ctrl_rw_q   <= 1'b0;
            ctrl_len_q  <= '0;
            ctrl_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wdog_q      <= wdog_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            mem_done_q  <= mem_done_d;
            mem_data_q  <= mem_data_d;
            ctrl_if_q   <= ctrl_if_d;
            ctrl_mem_q  <= ctrl_mem_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_rw_q   <= ctrl_rw_d;
            ctrl_len_q  <= ctrl_len_d;
            ctrl_data_q <= ctrl_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_if)       state_d = IF_BUSY;
                else if (grant_mem) state_d = MEM_BUSY;
            end
            IF_BUSY:  if (bus.if_flush_in | bus.ctrl_if_done_in | wdog_hit) state_d = DRAIN;
            MEM_BUSY: if (bus.ctrl_mem_done_in | wdog_hit) state_d = DRAIN;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        if_valid_d  = 1'b0;
        if_inst_d   = '0;
        mem_done_d  = 1'b0;
        mem_data_d  = '0;
        ctrl_if_d   = ctrl_if_q;
        ctrl_mem_d  = ctrl_mem_q;
        ctrl_addr_d = ctrl_addr_q;
        ctrl_rw_d   = ctrl_rw_q;
        ctrl_len_d  = ctrl_len_q;
        ctrl_data_d = ctrl_data_q;
        err_d       = err_q | wdog_abort;
        wdog_d      = '0;
        starve_d    = bus.if_req_in ? starve_q : '0;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    ctrl_if_d   = 1'b1;
                    ctrl_addr_d = bus.if_addr_in;
                    ctrl_rw_d   = 1'b0;
                    ctrl_len_d  = '0;
                    ctrl_data_d = '0;
                    starve_d    = '0;
                end else if (grant_mem) begin
                    ctrl_mem_d  = 1'b1;
                    ctrl_addr_d = bus.mem_addr_in;
                    ctrl_rw_d   = bus.mem_rw_in;
                    ctrl_len_d  = bus.mem_len_in;
                    ctrl_data_d = bus.mem_data_in;
                    if (bus.if_req_in && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (state_d == DRAIN) begin
                    ctrl_if_d   = 1'b0;
                    ctrl_mem_d  = 1'b0;
                    ctrl_addr_d = '0;
                    ctrl_rw_d   = 1'b0;
                    ctrl_len_d  = '0;
                    ctrl_data_d = '0;
                    if_valid_d  = if_fin;
                    if_inst_d   = if_fin ? bus.ctrl_if_inst_in : '0;
                    mem_done_d  = mem_fin;
                    mem_data_d  = (mem_fin & ~ctrl_rw_q) ? bus.ctrl_mem_data_in : '0;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.if_valid_out  = if_valid_q;
    assign bus.if_inst_out   = if_inst_q;
    assign bus.mem_done_out  = mem_done_q;
    assign bus.mem_data_out  = mem_data_q;
    assign bus.ctrl_if_out   = ctrl_if_q;
    assign bus.ctrl_mem_out  = ctrl_mem_q;
    assign bus.ctrl_addr_out = ctrl_addr_q;
    assign bus.ctrl_rw_out   = ctrl_rw_q;
    assign bus.ctrl_len_out  = ctrl_len_q;
    assign bus.ctrl_data_out = ctrl_data_q;
    assign bus.err_out       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural byte-serial controller plus
// scoreboard queues of expected grants, fetch results and load/store results.
module tb_mem_arbiter;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    mem_arbiter_if bus ();
    mem_arbiter #(.STARVE_LIMIT(2), .WDOG_CYCLES(64)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        bit          is_if;
        logic [31:0] addr;
        logic        rw;
        logic [2:0]  len;
        logic [31:0] data;
    } grant_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          if_lat = 5;
    int          mem_lat = 3;
    bit          resp_en = 1'b1;
    logic [31:0] if_inst_val = 32'h0;
    int          icnt = 0;
    int          mcnt = 0;
    grant_t      gq[$];
    logic [31:0] ifq[$];
    logic [31:0] mq[$];
    int          gcyc[$];
    int          gcnt = 0;
    int          vcnt = 0;
    logic        pif = 1'b0;
    logic        pmem = 1'b0;
    grant_t      g;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller model: done pulses if_lat/mem_lat cycles after its enable is seen.
    always @(posedge clk_in) begin
        if (!rst_in || !bus.ctrl_if_out) begin
            icnt <= 0;
            bus.ctrl_if_done_in <= 1'b0;
            bus.ctrl_if_inst_in <= 32'h0;
        end else if (bus.ctrl_if_done_in) begin
            bus.ctrl_if_done_in <= 1'b0;
        end else if (resp_en && icnt >= if_lat - 1) begin
            bus.ctrl_if_done_in <= 1'b1;
            bus.ctrl_if_inst_in <= if_inst_val;
            icnt <= 0;
        end else begin
            icnt <= icnt + 1;
        end
    end

    always @(posedge clk_in) begin
        if (!rst_in || !bus.ctrl_mem_out) begin
            mcnt <= 0;
            bus.ctrl_mem_done_in <= 1'b0;
            bus.ctrl_mem_data_in <= 32'h0;
        end else if (bus.ctrl_mem_done_in) begin
            bus.ctrl_mem_done_in <= 1'b0;
        end else if (resp_en && mcnt >= mem_lat - 1) begin
            bus.ctrl_mem_done_in <= 1'b1;
            bus.ctrl_mem_data_in <= bus.ctrl_rw_out ? 32'hFFFF_FFFF : mem_model(bus.ctrl_addr_out);
            mcnt <= 0;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    // Monitor: compares each grant, fetch result and load/store result with the scoreboard.
    always @(negedge clk_in) begin
        chk("both_enables", bus.ctrl_if_out & bus.ctrl_mem_out, 0);
        if ((bus.ctrl_if_out && !pif) || (bus.ctrl_mem_out && !pmem)) begin
            gcnt++;
            gcyc.push_back(cyc);
            chk("grant_unexpected", gq.size() == 0, 0);
            if (gq.size() != 0) begin
                g = gq.pop_front();
                chk("grant_kind", bus.ctrl_if_out, g.is_if);
                chk("grant_addr", bus.ctrl_addr_out, g.addr);
                chk("grant_payload", {bus.ctrl_rw_out, bus.ctrl_len_out, bus.ctrl_data_out},
                    {g.rw, g.len, g.data});
            end
        end
        pif  <= bus.ctrl_if_out;
        pmem <= bus.ctrl_mem_out;
        if (bus.if_valid_out) begin
            vcnt++;
            chk("if_valid_unexpected", ifq.size() == 0, 0);
            if (ifq.size() != 0) chk("if_inst", bus.if_inst_out, ifq.pop_front());
        end
        if (bus.mem_done_out) begin
            chk("mem_done_unexpected", mq.size() == 0, 0);
            if (mq.size() != 0) chk("mem_data", bus.mem_data_out, mq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_valid"}, bus.if_valid_out, 0);
        chk({tag, "_if_inst"}, bus.if_inst_out, 0);
        chk({tag, "_mem_done"}, bus.mem_done_out, 0);
        chk({tag, "_mem_data"}, bus.mem_data_out, 0);
        chk({tag, "_enables"}, {bus.ctrl_if_out, bus.ctrl_mem_out}, 0);
        chk({tag, "_ctrl_addr"}, bus.ctrl_addr_out, 0);
        chk({tag, "_ctrl_payload"}, {bus.ctrl_rw_out, bus.ctrl_len_out, bus.ctrl_data_out}, 0);
        chk({tag, "_err"}, bus.err_out, 0);
    endtask

    task automatic wait_if();
        for (int i = 0; i < 300 && !bus.if_valid_out; i++) step();
        chk("if_valid_timeout", bus.if_valid_out, 1);
        bus.if_req_in = 1'b0;
    endtask

    task automatic wait_mem();
        for (int i = 0; i < 300 && !bus.mem_done_out; i++) step();
        chk("mem_done_timeout", bus.mem_done_out, 1);
        bus.mem_req_in = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a, input logic [31:0] inst);
        if_inst_val = inst;
        gq.push_back('{1'b1, a, 1'b0, 3'd0, 32'd0});
        ifq.push_back(inst);
        bus.if_addr_in = a;
        bus.if_req_in  = 1'b1;
        wait_if();
    endtask

    task automatic set_mem(input logic rw, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] len);
        bus.mem_rw_in   = rw;
        bus.mem_addr_in = a;
        bus.mem_data_in = d;
        bus.mem_len_in  = len;
    endtask

    task automatic do_mem(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] len);
        gq.push_back('{1'b0, a, rw, len, d});
        mq.push_back(rw ? 32'h0 : mem_model(a));
        set_mem(rw, a, d, len);
        bus.mem_req_in = 1'b1;
        wait_mem();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, n, rel;
        bus.if_req_in = 1'b0; bus.if_addr_in = 32'h0; bus.if_flush_in = 1'b0;
        bus.mem_req_in = 1'b0;
        set_mem(1'b0, 32'h0, 32'h0, 3'd0);
        repeat (3) step();
        chk_zero("reset");
        rst_in = 1'b1;
        step();
        chk("idle_no_grant", {bus.ctrl_if_out, bus.ctrl_mem_out}, 0);

        // Single fetch: one valid pulse, then DRAIN and IDLE.
        if_lat = 5;
        base = vcnt;
        do_if(32'h100, 32'h0000_0013);
        chk("fetch_drain_en", bus.ctrl_if_out, 0);
        step();
        chk("fetch_pulse_once", bus.if_valid_out, 0);
        step();
        chk("fetch_valid_count", vcnt - base, 1);

        // Store then load.
        mem_lat = 3;
        do_mem(1'b1, 32'h20, 32'hDEAD_BEEF, 3'd4);
        step();
        do_mem(1'b0, 32'h44, 32'h55AA_55AA, 3'd1);
        step();

        // Both requesting continuously: M, M, I, M, M, I.
        if_inst_val = 32'h0000_0093;
        for (int k = 0; k < 6; k++) begin
            if (k == 2 || k == 5) begin
                gq.push_back('{1'b1, 32'h200, 1'b0, 3'd0, 32'd0});
                ifq.push_back(32'h0000_0093);
            end else begin
                gq.push_back('{1'b0, 32'h300, 1'b0, 3'd4, 32'd0});
                mq.push_back(mem_model(32'h300));
            end
        end
        set_mem(1'b0, 32'h300, 32'h0, 3'd4);
        bus.if_addr_in = 32'h200;
        base = gcnt;
        n = gcyc.size();
        bus.if_req_in = 1'b1;
        bus.mem_req_in = 1'b1;
        for (int i = 0; i < 400 && gcnt < base + 6; i++) step();
        chk("starve_grant_count", gcnt - base, 6);
        bus.mem_req_in = 1'b0;
        wait_if();
        step();
        chk("turnaround_mem", gcyc[n+1] - gcyc[n], mem_lat + 3);
        chk("turnaround_if", gcyc[n+3] - gcyc[n+2], if_lat + 3);

        // Flush in IDLE blocks the fetch grant.
        bus.if_addr_in = 32'h180;
        bus.if_req_in = 1'b1;
        bus.if_flush_in = 1'b1;
        repeat (3) step();
        chk("flush_idle_no_grant", bus.ctrl_if_out, 0);
        bus.if_flush_in = 1'b0;
        do_if(32'h180, 32'h0000_0033);
        step();

        // Flush on the same cycle as controller done, with MEM pending.
        if_lat = 4;
        base = vcnt;
        gq.push_back('{1'b1, 32'h400, 1'b0, 3'd0, 32'd0});
        bus.if_addr_in = 32'h400;
        bus.if_req_in = 1'b1;
        for (int i = 0; i < 50 && !bus.ctrl_if_done_in; i++) step();
        chk("flush_wait_done", bus.ctrl_if_done_in, 1);
        bus.if_flush_in = 1'b1;
        set_mem(1'b0, 32'h480, 32'h0, 3'd2);
        gq.push_back('{1'b0, 32'h480, 1'b0, 3'd2, 32'd0});
        mq.push_back(mem_model(32'h480));
        bus.mem_req_in = 1'b1;
        step();
        chk("flush_no_valid", bus.if_valid_out, 0);
        chk("flush_drain_en", {bus.ctrl_if_out, bus.ctrl_mem_out}, 0);
        bus.if_flush_in = 1'b0;
        bus.if_req_in = 1'b0;
        step();
        chk("drain_no_grant", bus.ctrl_mem_out, 0);
        step();
        chk("mem_after_flush", bus.ctrl_mem_out, 1);
        wait_mem();
        chk("flush_valid_count", vcnt - base, 0);
        step();

        // Watchdog: controller silent.
        resp_en = 1'b0;
        gq.push_back('{1'b0, 32'h500, 1'b0, 3'd4, 32'd0});
        set_mem(1'b0, 32'h500, 32'h0, 3'd4);
        n = gcyc.size();
        bus.mem_req_in = 1'b1;
        for (int i = 0; i < 200 && !bus.err_out; i++) step();
        chk("wdog_err", bus.err_out, 1);
        chk("wdog_cycles", cyc - gcyc[n], 64);
        chk("wdog_en_low", {bus.ctrl_if_out, bus.ctrl_mem_out}, 0);
        chk("wdog_no_done", bus.mem_done_out, 0);
        bus.mem_req_in = 1'b0;
        resp_en = 1'b1;
        step();
        step();
        chk("err_sticky", bus.err_out, 1);
        do_mem(1'b0, 32'h504, 32'h0, 3'd4);
        step();

        // Asynchronous reset mid MEM_BUSY, then fresh grant on release.
        mem_lat = 10;
        gq.push_back('{1'b0, 32'h600, 1'b1, 3'd2, 32'h1234});
        set_mem(1'b1, 32'h600, 32'h1234, 3'd2);
        bus.mem_req_in = 1'b1;
        repeat (3) step();
        chk("pre_reset_busy", bus.ctrl_mem_out, 1);
        #2 rst_in = 1'b0;
        #1;
        chk_zero("async_reset");
        step();
        step();
        gq.push_back('{1'b0, 32'h600, 1'b1, 3'd2, 32'h1234});
        mq.push_back(32'h0);
        n = gcyc.size();
        rst_in = 1'b1;
        rel = cyc;
        wait_mem();
        chk("regrant_first_edge", gcyc[n] - rel, 1);
        step();
        step();
        chk("scoreboard_drained", gq.size() + ifq.size() + mq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
